// File: rtl/fdct8x8.sv
// Forward 8x8 orthonormal DCT-II: row pass into a transpose RAM, then a column pass
// into the coefficient RAM, one multiply-accumulate per clock through a 2-stage pipe.
module fdct8x8 #(
    parameter int PIX_W  = 8,
    parameter int COEF_W = 16,
    parameter int FRAC   = 12,
    parameter int ACC_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_we,
    input  logic [5:0]               in_addr,
    input  logic [PIX_W-1:0]         in_data,
    input  logic                     start,
    output logic                     done,
    input  logic [5:0]               out_addr,
    output logic signed [COEF_W-1:0] out_data
);

    localparam int CW = FRAC + 1;
    localparam logic [PIX_W:0]          LVL    = {2'b01, {(PIX_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] HALF   = ACC_W'(2 ** (FRAC - 1));
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(2 ** (COEF_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(2 ** (COEF_W - 1)));

    typedef enum logic [1:0] {S_IDLE, S_ROW, S_COL, S_DONE} state_t;

    // Cosine ROM C[k][n] for FRAC = 12: fold (2n+1)k mod 32 onto the first quadrant.
    function automatic logic signed [CW-1:0] cos_coef(input logic [2:0] k, input logic [2:0] n);
        logic [4:0]           m;
        logic [4:0]           a;
        logic                 neg;
        logic signed [CW-1:0] mag;
        m = {1'b0, n, 1'b1} * {2'b00, k};
        if (m <= 5'd8) begin
            a = m;            neg = 1'b0;
        end else if (m <= 5'd16) begin
            a = 5'd16 - m;    neg = 1'b1;
        end else if (m <= 5'd24) begin
            a = m - 5'd16;    neg = 1'b1;
        end else begin
            a = 5'(6'd32 - {1'b0, m}); neg = 1'b0;
        end
        case (a)
            5'd1:    mag = CW'(2009);
            5'd2:    mag = CW'(1892);
            5'd3:    mag = CW'(1703);
            5'd4:    mag = CW'(1448);
            5'd5:    mag = CW'(1138);
            5'd6:    mag = CW'(784);
            5'd7:    mag = CW'(400);
            default: mag = '0;
        endcase
        if (k == 3'd0) return CW'(1448);
        return neg ? -mag : mag;
    endfunction

    state_t                    r_state, w_next;
    logic [9:0]                r_cnt;
    logic                      w_issue, w_open, w_accept;
    logic [PIX_W-1:0]          r_pix [64];
    logic signed [COEF_W-1:0]  r_tr  [64];
    logic signed [COEF_W-1:0]  r_fco [64];
    logic                      r_mac_vld, r_mac_last, r_mac_col;
    logic [5:0]                r_mac_dst;
    logic signed [COEF_W-1:0]  r_opd;
    logic signed [CW-1:0]      r_coef;
    logic signed [ACC_W-1:0]   r_acc, w_prod, w_sum, w_rnd, w_clip;
    logic signed [PIX_W:0]     w_pix_sh;
    logic signed [COEF_W-1:0]  w_opd;
    logic [5:0]                w_rd_addr, w_dst;

    assign w_open   = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_accept = w_open && start;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_next = S_ROW;
            S_ROW:          if (r_cnt == 10'd511) w_next = S_COL;
            S_COL:          if (r_cnt == 10'd0) w_next = S_DONE;
            default:        w_next = S_IDLE;
        endcase
    end

    // COL issues while r_cnt runs 512..1023; the wrap to 0 marks the pipeline drain cycle.
    always_comb begin
        w_issue = 1'b0;
        done    = 1'b0;
        case (r_state)
            S_ROW:   w_issue = 1'b1;
            S_COL:   w_issue = (r_cnt != 10'd0);
            S_DONE:  done    = 1'b1;
            default: ;
        endcase
    end

    // Row pass: r_cnt = {y,u,x}; column pass: r_cnt = {1,u,v,y}.
    always_comb begin
        if (r_cnt[9]) begin
            w_rd_addr = {r_cnt[2:0], r_cnt[8:6]};
            w_dst     = {r_cnt[5:3], r_cnt[8:6]};
        end else begin
            w_rd_addr = {r_cnt[8:6], r_cnt[2:0]};
            w_dst     = {r_cnt[8:6], r_cnt[5:3]};
        end
    end

    assign w_pix_sh = $signed({1'b0, r_pix[w_rd_addr]} - LVL);
    assign w_opd    = r_cnt[9] ? r_tr[w_rd_addr] : COEF_W'(w_pix_sh);

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_mac_vld  <= 1'b0;
            r_mac_last <= 1'b0;
            r_mac_col  <= 1'b0;
            r_mac_dst  <= '0;
            r_opd      <= '0;
            r_coef     <= '0;
        end else begin
            r_mac_vld <= w_issue;
            if (w_accept)     r_cnt <= '0;
            else if (w_issue) r_cnt <= r_cnt + 10'd1;
            if (w_issue) begin
                r_opd      <= w_opd;
                r_coef     <= cos_coef(r_cnt[5:3], r_cnt[2:0]);
                r_mac_last <= (r_cnt[2:0] == 3'd7);
                r_mac_col  <= r_cnt[9];
                r_mac_dst  <= w_dst;
            end
        end
    end

    assign w_prod = ACC_W'(r_opd) * ACC_W'(r_coef);
    assign w_sum  = r_acc + w_prod;
    assign w_rnd  = (w_sum + HALF) >>> FRAC;
    assign w_clip = (w_rnd > SAT_HI) ? SAT_HI : ((w_rnd < SAT_LO) ? SAT_LO : w_rnd);

    always_ff @(posedge clk) begin
        if (rst)            r_acc <= '0;
        else if (r_mac_vld) r_acc <= r_mac_last ? '0 : w_sum;
    end

    // NOTE: the RAMs carry no reset so they can map onto memory macros; contents persist through rst.
    always_ff @(posedge clk) begin
        if (in_we && w_open) r_pix[in_addr] <= in_data;
        if (r_mac_vld && r_mac_last && !r_mac_col) r_tr[r_mac_dst]  <= COEF_W'(w_rnd);
        if (r_mac_vld && r_mac_last && r_mac_col)  r_fco[r_mac_dst] <= COEF_W'(w_clip);
    end

    always_ff @(posedge clk) begin
        if (rst) out_data <= '0;
        else     out_data <= r_fco[out_addr];
    end

endmodule

// File: tb/tb_fdct8x8.sv
// Scoreboard bench for fdct8x8: a real-valued cosine table feeds a plain-loop
// fixed-point DCT model; a monitor pops expected coefficients as reads return.
module tb_fdct8x8;

    logic              clk = 1'b0;
    logic              rst, in_we, start, done;
    logic [5:0]        in_addr, out_addr;
    logic [7:0]        in_data;
    logic signed [15:0] out_data;

    fdct8x8 dut (
        .clk(clk), .rst(rst), .in_we(in_we), .in_addr(in_addr), .in_data(in_data),
        .start(start), .done(done), .out_addr(out_addr), .out_data(out_data)
    );

    always #5 clk = ~clk;

    typedef int blk_t [64];
    typedef struct { int idx; int val; } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   ctab [8][8];
    logic rd_issue = 1'b0;
    logic rd_vld   = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) rd_vld <= rd_issue;

    always @(negedge clk) begin
        exp_t e;
        if (rd_vld) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_underflow", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("coef[%0d]", e.idx), out_data, e.val);
            end
        end
    end

    task automatic build_ctab();
        real cu, v;
        for (int u = 0; u < 8; u++)
            for (int x = 0; x < 8; x++) begin
                cu = (u == 0) ? 1.0 / $sqrt(2.0) : 1.0;
                v  = 4096.0 * cu / 2.0 * $cos(real'((2 * x + 1) * u) * 3.14159265358979 / 16.0);
                ctab[u][x] = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
            end
    endtask

    task automatic dct_model(input blk_t p, output blk_t f);
        blk_t   t;
        longint acc, r;
        for (int y = 0; y < 8; y++)
            for (int u = 0; u < 8; u++) begin
                acc = 0;
                for (int x = 0; x < 8; x++) acc += longint'(p[8*y+x] - 128) * ctab[u][x];
                t[8*y+u] = int'((acc + 2048) >>> 12);
            end
        for (int u = 0; u < 8; u++)
            for (int v = 0; v < 8; v++) begin
                acc = 0;
                for (int y = 0; y < 8; y++) acc += longint'(t[8*y+u]) * ctab[v][y];
                r = (acc + 2048) >>> 12;
                if (r > 32767)  r = 32767;
                if (r < -32768) r = -32768;
                f[8*v+u] = int'(r);
            end
    endtask

    // With hold_last the final write is left on the bus so it coincides with start.
    task automatic load_block(input blk_t p, input bit hold_last);
        for (int i = 0; i < 64; i++) begin
            in_we   = 1'b1;
            in_addr = 6'(i);
            in_data = 8'(p[i]);
            if (i < 63 || !hold_last) begin
                @(posedge clk); #1;
            end
        end
        if (!hold_last) in_we = 1'b0;
    endtask

    // mode 0: plain run; 1: writes and a second start during ROW; 2: reset at ROW cycle 300.
    task automatic start_and_wait(input int mode);
        int cnt = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        in_we = 1'b0;
        check("done_clear", done, 0);
        while (done !== 1'b1 && cnt < 1100) begin
            @(posedge clk); #1;
            cnt++;
            if (mode == 2 && cnt == 300) begin
                rst = 1'b1;
                @(posedge clk); #1;
                check("abort_done", done, 0);
                check("abort_out_data", out_data, 0);
                rst = 1'b0;
                return;
            end
            if (mode == 1) begin
                in_we   = (cnt >= 5 && cnt < 13);
                in_addr = 6'($urandom);
                in_data = 8'($urandom);
                start   = (cnt == 20);
            end
        end
        in_we = 1'b0;
        start = 1'b0;
        check("done_latency", cnt, 1025);
    endtask

    task automatic read_all(input blk_t e);
        exp_t x;
        for (int i = 0; i < 64; i++) begin
            out_addr = 6'(i);
            rd_issue = 1'b1;
            x.idx = i;
            x.val = e[i];
            exp_q.push_back(x);
            @(posedge clk); #1;
        end
        rd_issue = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        blk_t p, e;
        int   lv  [4] = '{128, 192, 0, 255};
        int   dcv [4] = '{0, 512, -1024, 1015};

        build_ctab();
        rst = 1'b1; in_we = 1'b0; start = 1'b0;
        in_addr = '0; in_data = '0; out_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", done, 0);
        check("rst_out_data", out_data, 0);
        rst = 1'b0;

        // Flat blocks: only the DC term survives, with hand-derived values.
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 64; i++) begin
                p[i] = lv[k];
                e[i] = (i == 0) ? dcv[k] : 0;
            end
            load_block(p, 1'b0);
            start_and_wait(0);
            read_all(e);
        end

        // Horizontal ramp.
        for (int i = 0; i < 64; i++) p[i] = 16 * (i % 8);
        dct_model(p, e);
        load_block(p, 1'b0);
        start_and_wait(0);
        read_all(e);

        // Random blocks; first overlaps the last write with start, second runs back-to-back.
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < 64; i++) p[i] = int'($urandom_range(255));
            dct_model(p, e);
            load_block(p, k == 0);
            start_and_wait(0);
            if (k == 1) start_and_wait(0);
            read_all(e);
        end

        // Writes and a stray start during ROW must not disturb the running transform.
        for (int i = 0; i < 64; i++) p[i] = int'($urandom_range(255));
        dct_model(p, e);
        load_block(p, 1'b0);
        start_and_wait(1);
        read_all(e);

        // Abort mid-ROW, then restart from the retained pixels.
        for (int i = 0; i < 64; i++) p[i] = int'($urandom_range(255));
        dct_model(p, e);
        load_block(p, 1'b0);
        start_and_wait(2);
        start_and_wait(0);
        read_all(e);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
